fft_mag_frontend: RTL and testbench
===================================

Name: fft_mag_frontend

Overview:
- Upstream neighbour of the serial output stage.
- Takes the two complex samples per cycle from the streaming 2048-point FFT core and turns them into two 12-bit unsigned magnitudes per cycle.
- Uses an alpha-max/beta-min approximation.
- Regenerates the frame-start pulse (mag_next_out) so the serial buffer latches a whole 1024-cycle frame, and tracks frame position, completion and overrun.

Parameters:
IN_W, 16, signed width of each FFT real/imag component
OUT_W, 12, unsigned magnitude width delivered downstream
SHIFT, 5, right shift applied to the (IN_W+1)-bit magnitude sum before saturation to OUT_W
N_PAIRS, 1024, output cycles per frame (2 samples per cycle, so 2048 bins)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
fft_next_out  in  1  FFT core pulse, one cycle before the first sample pair of a frame
x0_re  in  IN_W  sample 2k, real, signed
x0_im  in  IN_W  sample 2k, imaginary, signed
x1_re  in  IN_W  sample 2k+1, real, signed
x1_im  in  IN_W  sample 2k+1, imaginary, signed
mag_next_out  out  1  pulse one cycle before the first magnitude pair; drives serial stage next_out
mag_out1  out  OUT_W  magnitude of sample 2k
mag_out2  out  OUT_W  magnitude of sample 2k+1
mag_valid  out  1  high on every cycle carrying a frame pair
frame_done  out  1  one-cycle pulse coincident with the last pair (index N_PAIRS-1)
overrun  out  1  sticky; new frame start while a frame is still in flight

Behaviour:
- Reset: reset_n synchronous, active-low; clock clk.
  - While reset_n=0, every output register, pipeline register, delay line and counter clears to 0.
  - Reset mid-frame abandons the frame; no frame_done is issued for it.
- Input timing: FFT data are valid on the N_PAIRS consecutive cycles after fft_next_out.
- Pipeline, 4 registered stages; latency 4 cycles from input to output.
  - S1: absolute value per component, saturating -2^(IN_W-1) to 2^(IN_W-1)-1.
  - S2: per sample, mx = max(|re|,|im|) and mn = min(|re|,|im|).
  - S3: sum = mx + (mn>>2) + (mn>>3), width IN_W+1, no overflow possible.
  - S4: v = sum >> SHIFT; v > 2^OUT_W-1 saturates to 2^OUT_W-1; result registered to mag_out1/mag_out2.
- Frame control FSM:
  - States: IDLE, ARM, RUN.
  - IDLE: fft_next_out=1 -> ARM.
  - ARM: lasts 1 cycle; pair counter cleared -> RUN.
  - RUN: counter increments each cycle. At count N_PAIRS-1 -> IDLE, or -> ARM if fft_next_out=1 on the same cycle (back-to-back frames, no overrun).
  - fft_next_out=1 in RUN before the last count sets overrun, restarts the counter at 0 and moves to ARM. The old frame is truncated and gets no frame_done.
- Control delay line: frame-start and in-frame flags are carried through a delay line equal to the data pipeline depth.
  - mag_next_out is fft_next_out delayed 4 cycles, so it still precedes the first output pair by exactly 1 cycle.
  - mag_valid and frame_done are aligned with mag_out*.
- Between frames mag_out1/mag_out2 hold their last values; mag_valid=0.
- overrun clears only on reset.

Decomposition:
- Shared package (fmcw_dsp_pkg):
  - Constants FFT_N=2048, FFT_PAIRS=1024, FFT_IN_W=16, MAG_W=12, MAG_LAT=4.
  - Enum for the frame FSM states.
- One natural sub-module: mag_approx. It holds the 4-stage single-sample magnitude pipeline (abs, max/min, sum, shift/saturate) and is instantiated twice, for x0 and x1.
- The FSM, pair counter and control delay line live in the top module.

Test Plan:
- Single frame: fft_next_out at cycle 0, x0=(3000,4000), x1=(-4000,3000) constant for 1024 cycles.
  - mag_next_out at cycle 4.
  - mag_out1=mag_out2=160 with mag_valid=1 on cycles 5..1028.
  - frame_done only at cycle 1028.
- Saturating abs: x0=(-32768,-32768) -> mag_out1=1407. With SHIFT=0 override: x0=(32767,32767) -> mag_out1=4095.
- Zero and single-axis inputs:
  - x0=(0,0) -> 0.
  - x1=(0,-1024) -> 32.
  - x0=(640,0) -> 20.
- Back-to-back frames: second fft_next_out on the last pair cycle of frame 1.
  - Exactly 2048 consecutive valid cycles and two frame_done pulses.
  - overrun stays 0.
- Early restart: second fft_next_out at pair 500.
  - overrun=1 (sticky).
  - No frame_done for frame 1.
  - Second frame then delivers a full 1024 valid cycles with frame_done.
- Reset at pair 300 (reset_n low 2 cycles):
  - All outputs 0 on the next cycle.
  - No frame_done.
  - Next fft_next_out yields a clean full frame.

Source files
------------

// File: rtl/fmcw_dsp_pkg.sv
// Shared constants and types for the FMCW DSP chain between the FFT core
// and the serial output stage.
package fmcw_dsp_pkg;

  localparam int unsigned FFT_N     = 2048;
  localparam int unsigned FFT_PAIRS = 1024;
  localparam int unsigned FFT_IN_W  = 16;
  localparam int unsigned MAG_W     = 12;
  localparam int unsigned MAG_LAT   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } frame_state_t;

  // Control flags that travel alongside the data pipeline
  typedef struct packed {
    logic start;
    logic valid;
    logic last;
  } frame_ctl_t;

endpackage

// File: rtl/mag_approx.sv
// Four-stage alpha-max/beta-min magnitude of one complex sample:
// saturating abs, max/min, mx + mn/4 + mn/8, shift and saturate.
module mag_approx
  import fmcw_dsp_pkg::*;
#(
  parameter int unsigned IN_W  = FFT_IN_W,
  parameter int unsigned OUT_W = MAG_W,
  parameter int unsigned SHIFT = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic signed [IN_W-1:0] re,
  input  logic signed [IN_W-1:0] im,
  output logic [OUT_W-1:0]       mag
);

  localparam int unsigned AW = IN_W - 1;
  localparam int unsigned SW = IN_W + 1;

  // Most negative input folds onto the most positive representable value
  function automatic logic [AW-1:0] sat_abs(input logic signed [IN_W-1:0] x);
    if (x == {1'b1, {AW{1'b0}}}) return {AW{1'b1}};
    else if (x[IN_W-1])           return AW'(-x);
    else                          return x[AW-1:0];
  endfunction

  logic [AW-1:0]    abs_re, abs_im;
  logic [AW-1:0]    mx, mn;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    shifted;
  logic [OUT_W-1:0] sat;

  always_comb begin
    shifted = sum >> SHIFT;
    sat     = (shifted > SW'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
  end

  // The output stage only loads on frame cycles so idle data never leaks out
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      abs_re <= '0;
      abs_im <= '0;
      mx     <= '0;
      mn     <= '0;
      sum    <= '0;
      mag    <= '0;
    end else begin
      abs_re <= sat_abs(re);
      abs_im <= sat_abs(im);
      mx     <= (abs_re >= abs_im) ? abs_re : abs_im;
      mn     <= (abs_re >= abs_im) ? abs_im : abs_re;
      sum    <= SW'(mx) + SW'(mn >> 2) + SW'(mn >> 3);
      if (load) mag <= sat;
    end
  end

endmodule

// File: rtl/fft_mag_frontend.sv
// Converts FFT sample pairs into magnitude pairs and regenerates frame
// timing (start pulse, valid, last pair, overrun) for the serial stage.
module fft_mag_frontend
  import fmcw_dsp_pkg::*;
#(
  parameter int unsigned IN_W    = FFT_IN_W,
  parameter int unsigned OUT_W   = MAG_W,
  parameter int unsigned SHIFT   = 5,
  parameter int unsigned N_PAIRS = FFT_PAIRS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fft_next_out,
  input  logic signed [IN_W-1:0] x0_re,
  input  logic signed [IN_W-1:0] x0_im,
  input  logic signed [IN_W-1:0] x1_re,
  input  logic signed [IN_W-1:0] x1_im,
  output logic                   mag_next_out,
  output logic [OUT_W-1:0]       mag_out1,
  output logic [OUT_W-1:0]       mag_out2,
  output logic                   mag_valid,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam int unsigned CW = $clog2(N_PAIRS);

  frame_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          overrun_nxt;
  frame_ctl_t    ctl_in;
  frame_ctl_t    dly [MAG_LAT];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      overrun <= overrun_nxt;
    end
  end

  // cnt always holds the index of the pair present on the inputs this cycle
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    overrun_nxt = overrun;
    ctl_in      = '0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (fft_next_out) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (fft_next_out) begin
          overrun_nxt = 1'b1;
          cnt_nxt     = '0;
        end else begin
          state_nxt = ST_RUN;
          cnt_nxt   = CW'(1);
        end
      end
      ST_RUN: begin
        if (cnt == CW'(N_PAIRS - 1)) begin
          cnt_nxt   = '0;
          state_nxt = fft_next_out ? ST_ARM : ST_IDLE;
        end else if (fft_next_out) begin
          overrun_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = ST_ARM;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    ctl_in.start = fft_next_out;
    ctl_in.valid = (state != ST_IDLE);
    ctl_in.last  = (state == ST_RUN) && (cnt == CW'(N_PAIRS - 1));
  end

  // Delay line matched to the magnitude pipeline depth
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(MAG_LAT); i++) dly[i] <= '0;
    end else begin
      dly[0] <= ctl_in;
      for (int i = 1; i < int'(MAG_LAT); i++) dly[i] <= dly[i-1];
    end
  end

  assign mag_next_out = dly[MAG_LAT-1].start;
  assign mag_valid    = dly[MAG_LAT-1].valid;
  assign frame_done   = dly[MAG_LAT-1].last;

  mag_approx #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_mag0 (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (dly[MAG_LAT-2].valid),
    .re      (x0_re),
    .im      (x0_im),
    .mag     (mag_out1)
  );

  mag_approx #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_mag1 (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (dly[MAG_LAT-2].valid),
    .re      (x1_re),
    .im      (x1_im),
    .mag     (mag_out2)
  );

endmodule

// File: tb/tb_fft_mag_frontend.sv
// Scoreboard bench: driver pushes hand-computed magnitudes per pair, monitor
// pops and compares on every mag_valid cycle; a SHIFT=0 instance runs in lockstep.
module tb_fft_mag_frontend;

  localparam int N = 1024;

  logic clk = 1'b0;
  logic reset_n;
  logic fft_next_out;
  logic signed [15:0] x0_re, x0_im, x1_re, x1_im;
  logic        mag_next_out, mag_valid, frame_done, overrun;
  logic [11:0] mag_out1, mag_out2;
  logic        z_next, z_valid, z_done, z_overrun;
  logic [11:0] z_out1, z_out2;

  always #5 clk = ~clk;

  fft_mag_frontend dut (
    .clk(clk), .reset_n(reset_n), .fft_next_out(fft_next_out),
    .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
    .mag_next_out(mag_next_out), .mag_out1(mag_out1), .mag_out2(mag_out2),
    .mag_valid(mag_valid), .frame_done(frame_done), .overrun(overrun)
  );

  fft_mag_frontend #(.SHIFT(0)) dut_s0 (
    .clk(clk), .reset_n(reset_n), .fft_next_out(fft_next_out),
    .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
    .mag_next_out(z_next), .mag_out1(z_out1), .mag_out2(z_out2),
    .mag_valid(z_valid), .frame_done(z_done), .overrun(z_overrun)
  );

  // Vectors and hand-computed magnitudes (SHIFT=5 and SHIFT=0)
  int v0r[6] = '{3000, -32768, 32767, 0, 640, 100};
  int v0i[6] = '{4000, -32768, 32767, 0, 0, -7};
  int v1r[6] = '{-4000, 0, 640, 0, -32768, -2048};
  int v1i[6] = '{3000, -1024, 0, -1024, -32768, 4096};
  int e1[6]  = '{160, 1407, 1407, 0, 20, 3};
  int e2[6]  = '{160, 32, 20, 32, 1407, 152};
  int z1[6]  = '{4095, 4095, 4095, 0, 640, 101};
  int z2[6]  = '{4095, 1024, 640, 1024, 4095, 4095};

  typedef struct {
    int m1; int m2; int s1; int s2; bit first; bit last;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0, done_cnt = 0, cur_run = 0, last_run = 0;
  int last_m1 = 0, last_m2 = 0;
  bit prev_next = 1'b0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        last_m1 = 0; last_m2 = 0; prev_next = 1'b0; cur_run = 0;
      end else begin
        if (mag_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_valid", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("mag_out1", int'(mag_out1), e.m1);
            chk("mag_out2", int'(mag_out2), e.m2);
            chk("s0_mag_out1", int'(z_out1), e.s1);
            chk("s0_mag_out2", int'(z_out2), e.s2);
            chk("frame_done", int'(frame_done), int'(e.last));
            chk("next_precedes_first", int'(prev_next), int'(e.first));
          end
          last_m1 = int'(mag_out1); last_m2 = int'(mag_out2);
          cur_run++; valid_cnt++;
        end else begin
          chk("hold_out1", int'(mag_out1), last_m1);
          chk("hold_out2", int'(mag_out2), last_m2);
          chk("done_idle", int'(frame_done), 0);
          chk("next_without_data", int'(prev_next), 0);
          if (cur_run != 0) last_run = cur_run;
          cur_run = 0;
        end
        if (frame_done) done_cnt++;
        chk("s0_valid", int'(z_valid), int'(mag_valid));
        chk("s0_next", int'(z_next), int'(mag_next_out));
        prev_next = mag_next_out;
      end
    end
  end

  task automatic step(input bit nxt, input int vi, input bit push,
                      input bit first, input bit last);
    fft_next_out = nxt;
    x0_re = 16'(v0r[vi]); x0_im = 16'(v0i[vi]);
    x1_re = 16'(v1r[vi]); x1_im = 16'(v1i[vi]);
    if (push) sb.push_back('{e1[vi], e2[vi], z1[vi], z2[vi], first, last});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse();
    step(1'b1, 5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pairs(input int to, input bit mixed, input bit done, input bit chain);
    for (int k = 0; k <= to; k++)
      step(chain && (k == to), mixed ? (k % 6) : 0, 1'b1, k == 0, done && (k == N - 1));
  endtask

  task automatic frame_check(input string tag, input int vc0, input int dc0,
                             input int nv, input int nd, input int run, input int ovr);
    idle(12);
    chk({tag, "_drained"}, sb.size(), 0);
    chk({tag, "_valid_cycles"}, valid_cnt - vc0, nv);
    chk({tag, "_done_pulses"}, done_cnt - dc0, nd);
    if (run >= 0) chk({tag, "_run_len"}, last_run, run);
    chk({tag, "_overrun"}, int'(overrun), ovr);
    chk({tag, "_s0_overrun"}, int'(z_overrun), ovr);
  endtask

  initial begin
    int vc, dc;
    reset_n = 1'b0; fft_next_out = 1'b0;
    x0_re = '0; x0_im = '0; x1_re = '0; x1_im = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out1", int'(mag_out1), 0);
    chk("rst_out2", int'(mag_out2), 0);
    chk("rst_valid", int'(mag_valid), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_next", int'(mag_next_out), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset_n = 1'b1;
    idle(3);

    // Single constant frame
    vc = valid_cnt; dc = done_cnt;
    pulse(); pairs(N - 1, 1'b0, 1'b1, 1'b0);
    frame_check("single", vc, dc, N, 1, N, 0);

    // Mixed vectors: saturation, zero, single-axis
    vc = valid_cnt; dc = done_cnt;
    pulse(); pairs(N - 1, 1'b1, 1'b1, 1'b0);
    frame_check("mixed", vc, dc, N, 1, N, 0);

    // Back-to-back frames
    vc = valid_cnt; dc = done_cnt;
    pulse(); pairs(N - 1, 1'b1, 1'b1, 1'b1); pairs(N - 1, 1'b1, 1'b1, 1'b0);
    frame_check("b2b", vc, dc, 2 * N, 2, 2 * N, 0);

    // Early restart at pair 500
    vc = valid_cnt; dc = done_cnt;
    pulse(); pairs(500, 1'b1, 1'b0, 1'b1); pairs(N - 1, 1'b1, 1'b1, 1'b0);
    frame_check("early", vc, dc, 501 + N, 1, 501 + N, 1);
    idle(20);
    chk("overrun_sticky", int'(overrun), 1);

    // Reset at pair 300
    vc = valid_cnt; dc = done_cnt;
    pulse(); pairs(299, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    step(1'b0, 5, 1'b0, 1'b0, 1'b0);
    chk("midrst_out1", int'(mag_out1), 0);
    chk("midrst_out2", int'(mag_out2), 0);
    chk("midrst_valid", int'(mag_valid), 0);
    chk("midrst_done", int'(frame_done), 0);
    chk("midrst_next", int'(mag_next_out), 0);
    chk("midrst_overrun", int'(overrun), 0);
    sb.delete();
    step(1'b0, 5, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    frame_check("reset", vc, dc, 296, 0, -1, 0);

    vc = valid_cnt; dc = done_cnt;
    pulse(); pairs(N - 1, 1'b1, 1'b1, 1'b0);
    frame_check("post_reset", vc, dc, N, 1, N, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
